// File: rtl/seq_fsm.sv
// seq_fsm: bounded up/down state sequencer with step, load and timed run modes.
// Wraps or saturates at the ends, and recovers from illegal encodings with a sticky fault flag.
module seq_fsm #(
   parameter int NUM_STATES = 6,
   parameter int SW         = 3,
   parameter int WRAP       = 1,
   parameter int DWELL      = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [2:0]    user_input,
   input  logic [SW-1:0] load_val,
   output logic [SW-1:0] out,
   output logic          wrap_p,
   output logic          fault
);

   localparam logic [2:0] CMD_HOLD  = 3'b000;
   localparam logic [2:0] CMD_FWD   = 3'b001;
   localparam logic [2:0] CMD_BACK  = 3'b010;
   localparam logic [2:0] CMD_LOAD  = 3'b011;
   localparam logic [2:0] CMD_RUN_F = 3'b100;
   localparam logic [2:0] CMD_RUN_B = 3'b101;

   localparam int            LAST_I      = NUM_STATES - 1;
   localparam logic [SW-1:0] LAST_ST     = LAST_I[SW-1:0];
   localparam logic [SW:0]   NUM_EXT     = NUM_STATES[SW:0];
   localparam int            DWELL_M1    = DWELL - 1;
   localparam logic [7:0]    DWELL_LAST  = DWELL_M1[7:0];
   localparam bit            HAS_ILLEGAL = (NUM_STATES < (1 << SW));
   localparam bit            DO_WRAP     = (WRAP != 0);

   logic [SW-1:0] state_q, state_d;
   logic [7:0]    dwell_q, dwell_d;
   logic [2:0]    cmd_q;
   logic          wrap_q, wrap_d;
   logic          fault_q, fault_d;

   logic [SW-1:0] fwd_st, back_st;
   logic          fwd_wrap, back_wrap;
   logic          illegal, load_ok, run_step;
   logic [7:0]    dwell_eff;

   // Candidate neighbours in both directions, with the end-of-range policy applied.
   always_comb begin
      fwd_st    = state_q + 1'b1;
      fwd_wrap  = 1'b0;
      back_st   = state_q - 1'b1;
      back_wrap = 1'b0;
      if (state_q == LAST_ST) begin
         fwd_st   = DO_WRAP ? '0 : state_q;
         fwd_wrap = DO_WRAP;
      end
      if (state_q == '0) begin
         back_st   = DO_WRAP ? LAST_ST : state_q;
         back_wrap = DO_WRAP;
      end
   end

   assign illegal = HAS_ILLEGAL && ({1'b0, state_q} >= NUM_EXT);
   assign load_ok = ({1'b0, load_val} < NUM_EXT);

   // Any change of command restarts the dwell count from zero.
   assign dwell_eff = (user_input == cmd_q) ? dwell_q : 8'd0;
   assign run_step  = (dwell_eff == DWELL_LAST);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      dwell_d = 8'd0;
      wrap_d  = 1'b0;
      fault_d = fault_q;
      if (illegal) begin
         state_d = '0;
         fault_d = 1'b1;
      end else begin
         case (user_input)
            CMD_FWD: begin
               state_d = fwd_st;
               wrap_d  = fwd_wrap;
            end
            CMD_BACK: begin
               state_d = back_st;
               wrap_d  = back_wrap;
            end
            CMD_LOAD: begin
               if (load_ok) state_d = load_val;
               else         fault_d = 1'b1;
            end
            CMD_RUN_F: begin
               if (run_step) begin
                  state_d = fwd_st;
                  wrap_d  = fwd_wrap;
               end else begin
                  dwell_d = dwell_eff + 8'd1;
               end
            end
            CMD_RUN_B: begin
               if (run_step) begin
                  state_d = back_st;
                  wrap_d  = back_wrap;
               end else begin
                  dwell_d = dwell_eff + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
         dwell_q <= 8'd0;
         cmd_q   <= CMD_HOLD;
         wrap_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
         cmd_q   <= user_input;
         wrap_q  <= wrap_d;
         fault_q <= fault_d;
      end
   end

   assign out    = state_q;
   assign wrap_p = wrap_q;
   assign fault  = fault_q;

   a_fault_sticky: assert property (@(posedge clk) disable iff (rst) fault_q |=> fault_q);

   generate
      if (!DO_WRAP) begin : g_sat_chk
         a_no_wrap: assert property (@(posedge clk) disable iff (rst) !wrap_q);
      end
   endgenerate

endmodule

// File: tb/tb_seq_fsm.sv
// Bench for seq_fsm: a wrapping DWELL=4 instance and a saturating DWELL=1 instance share
// directed and random stimulus, checked every cycle against a behavioural model plus literals.
module tb_seq_fsm;

   localparam int P_N = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] user_input = 3'b000;
   logic [2:0] load_val = 3'd0;
   logic [2:0] out0, out1;
   logic       wrap0, wrap1, fault0, fault1;

   int n_cmp = 0;
   int n_fail = 0;

   int       p_wrap[2]  = '{1, 0};
   int       p_dwell[2] = '{4, 1};
   int       m_state[2] = '{0, 0};
   int       m_run[2]   = '{0, 0};
   int       m_prev[2]  = '{0, 0};
   bit       m_wrap[2]  = '{1'b0, 1'b0};
   bit       m_fault[2] = '{1'b0, 1'b0};

   logic [2:0] s_cmd, s_lv;
   logic       s_rst;

   seq_fsm #(.NUM_STATES(6), .SW(3), .WRAP(1), .DWELL(4)) dut (
      .clk(clk), .rst(rst), .user_input(user_input), .load_val(load_val),
      .out(out0), .wrap_p(wrap0), .fault(fault0)
   );

   seq_fsm #(.NUM_STATES(6), .SW(3), .WRAP(0), .DWELL(1)) dut_s (
      .clk(clk), .rst(rst), .user_input(user_input), .load_val(load_val),
      .out(out1), .wrap_p(wrap1), .fault(fault1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Position arithmetic on an integer line of P_N slots.
   task automatic model_move(input int i, input int d);
      int n;
      n = m_state[i] + d;
      if (n < 0 || n >= P_N) begin
         if (p_wrap[i] != 0) begin
            n = (n + P_N) % P_N;
            m_wrap[i] = 1'b1;
         end else begin
            n = m_state[i];
         end
      end
      m_state[i] = n;
   endtask

   // Run mode steps on every DWELL-th consecutive cycle of the same run command.
   task automatic model_tick(input int i, input int c, input int lv, input logic r);
      m_wrap[i] = 1'b0;
      if (r) begin
         m_state[i] = 0; m_fault[i] = 1'b0; m_run[i] = 0; m_prev[i] = 0;
      end else if (m_state[i] >= P_N) begin
         m_state[i] = 0; m_fault[i] = 1'b1; m_run[i] = 0; m_prev[i] = c;
      end else begin
         if (c == 4 || c == 5) m_run[i] = (c == m_prev[i]) ? m_run[i] + 1 : 1;
         else                  m_run[i] = 0;
         m_prev[i] = c;
         case (c)
            1: model_move(i, 1);
            2: model_move(i, -1);
            3: if (lv < P_N) m_state[i] = lv; else m_fault[i] = 1'b1;
            4: if (m_run[i] % p_dwell[i] == 0) model_move(i, 1);
            5: if (m_run[i] % p_dwell[i] == 0) model_move(i, -1);
            default: ;
         endcase
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         s_cmd = user_input;
         s_lv  = load_val;
         s_rst = rst;
         for (int i = 0; i < 2; i++) model_tick(i, int'(s_cmd), int'(s_lv), s_rst);
         #1;
         check("model_out_w", out0, m_state[0]);
         check("model_wrap_w", wrap0, m_wrap[0]);
         check("model_fault_w", fault0, m_fault[0]);
         check("model_out_s", out1, m_state[1]);
         check("model_wrap_s", wrap1, m_wrap[1]);
         check("model_fault_s", fault1, m_fault[1]);
      end
   end

   task automatic cyc(input logic [2:0] c, input logic [2:0] lv, input logic r);
      @(negedge clk);
      user_input = c;
      load_val   = lv;
      rst        = r;
      @(posedge clk);
      #2;
   endtask

   // Plant an unreachable encoding in the wrapping instance while a legal load is pending.
   task automatic upset(input logic [2:0] bad);
      @(negedge clk);
      user_input = 3'b011;
      load_val   = 3'd3;
      rst        = 1'b0;
      force dut.state_q = bad;
      m_state[0] = int'(bad);
      #1 release dut.state_q;
      @(posedge clk);
      #2;
      check("upset_out", out0, 0);
      check("upset_fault", fault0, 1);
      check("upset_other_load", out1, 3);
   endtask

   initial begin
      int exp_w[7];
      int exp_s[7];
      exp_w = '{1, 2, 3, 4, 5, 0, 1};
      exp_s = '{1, 2, 3, 4, 5, 5, 5};

      cyc(3'b000, 3'd0, 1'b1);
      cyc(3'b001, 3'd0, 1'b1);
      check("reset_out", out0, 0);
      check("reset_wrap", wrap0, 0);
      check("reset_fault", fault0, 0);

      for (int k = 0; k < 7; k++) begin
         cyc(3'b001, 3'd0, 1'b0);
         check($sformatf("wrap_out_%0d", k), out0, exp_w[k]);
         check($sformatf("wrap_p_%0d", k), wrap0, (k == 5));
         check($sformatf("sat_out_%0d", k), out1, exp_s[k]);
         check($sformatf("sat_wrap_%0d", k), wrap1, 0);
      end

      cyc(3'b011, 3'd5, 1'b0);
      check("sat_load5", out1, 5);
      for (int k = 0; k < 2; k++) begin
         cyc(3'b001, 3'd0, 1'b0);
         check("sat_hold_top", out1, 5);
         check("sat_top_wrap", wrap1, 0);
      end
      cyc(3'b000, 3'd0, 1'b1);
      cyc(3'b010, 3'd0, 1'b0);
      check("sat_bottom", out1, 0);
      check("wrap_back_out", out0, 5);
      check("wrap_back_p", wrap0, 1);

      cyc(3'b000, 3'd0, 1'b1);
      cyc(3'b000, 3'd0, 1'b0);
      for (int k = 1; k <= 12; k++) begin
         cyc(3'b100, 3'd0, 1'b0);
         if (k == 3) check("run_not_yet", out0, 0);
         if (k % 4 == 0) check($sformatf("run_fwd_%0d", k), out0, k / 4);
      end
      cyc(3'b100, 3'd0, 1'b0);
      cyc(3'b100, 3'd0, 1'b0);
      check("run_fwd_mid", out0, 3);
      for (int k = 1; k <= 4; k++) begin
         cyc(3'b101, 3'd0, 1'b0);
         check($sformatf("run_back_%0d", k), out0, (k < 4) ? 3 : 2);
      end
      check("run_dwell1_sat", out1, 1);

      cyc(3'b011, 3'd7, 1'b0);
      check("bad_load_out", out0, 2);
      check("bad_load_fault", fault0, 1);
      check("bad_load_fault_s", fault1, 1);
      cyc(3'b001, 3'd0, 1'b0);
      check("fault_sticky_step", fault0, 1);
      cyc(3'b011, 3'd3, 1'b0);
      check("fault_sticky_load", fault0, 1);
      cyc(3'b000, 3'd0, 1'b0);
      check("fault_sticky_hold", fault0, 1);
      cyc(3'b000, 3'd0, 1'b1);
      check("fault_cleared", fault0, 0);

      upset(3'd6);
      upset(3'd7);

      cyc(3'b000, 3'd0, 1'b1);
      for (int k = 0; k < 18; k++) cyc(3'b100, 3'd0, 1'b0);
      check("midrun_out", out0, 4);
      cyc(3'b100, 3'd0, 1'b1);
      check("midrun_rst_out", out0, 0);
      check("midrun_rst_fault", fault0, 0);
      check("midrun_rst_wrap", wrap0, 0);
      for (int k = 1; k <= 4; k++) begin
         cyc(3'b100, 3'd0, 1'b0);
         check($sformatf("post_rst_run_%0d", k), out0, (k < 4) ? 0 : 1);
      end

      for (int b = 0; b < 400; b++) begin
         int r;
         int len;
         logic [2:0] c;
         r = $urandom_range(0, 99);
         c = (r < 8)  ? 3'd0 : (r < 20) ? 3'd1 : (r < 32) ? 3'd2 : (r < 46) ? 3'd3 :
             (r < 70) ? 3'd4 : (r < 92) ? 3'd5 : (r < 96) ? 3'd6 : 3'd7;
         len = $urandom_range(1, 12);
         for (int k = 0; k < len; k++)
            cyc(c, 3'($urandom_range(0, 7)), ($urandom_range(0, 99) == 0));
         if ($urandom_range(0, 49) == 0) upset(($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
